decompressor: RTL and testbench
===============================

DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default 32, byte-enable width (DATA_WIDTH/8).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, run-length count field width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  compressed stream data.
REQ-007 SHALL have port tvalid_in  input  1  upstream beat valid.
REQ-008 SHALL have port tlast_in  input  1  upstream last beat of packet.
REQ-009 SHALL have port tready_in  input  1  downstream ready.
REQ-010 SHALL have port tkeep_in  input  KEEP_WIDTH  upstream byte enables.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  decompressed data, registered.
REQ-012 SHALL have port tvalid_out  output  1  output beat valid, registered.
REQ-013 SHALL have port tlast_out  output  1  output last beat, registered.
REQ-014 SHALL have port tready_out  output  1  ready to upstream.
REQ-015 SHALL have port tkeep_out  output  KEEP_WIDTH  output byte enables, registered.
REQ-016 SHALL have port pkt_count  output  32  count of completed output packets.
REQ-017 SHALL have port zero_beats  output  32  count of zero beats synthesised from run tokens.

Function
REQ-018 SHALL classify an accepted input beat (tvalid_in && tready_out) with tkeep_in == 0 as a run token, count C = data_in[CNT_WIDTH-1:0]; C == 0 SHALL be treated as 1.
REQ-019 SHALL classify every other accepted beat as literal; data_in, tkeep_in, tlast_in SHALL appear unchanged on outputs with tvalid_out high on the next cycle (latency 1).
REQ-020 SHALL expand a run token into exactly C output beats: data_out all zeros, tkeep_out all ones; tlast_out high only on the C-th beat and only if the token's tlast_in was high.
REQ-021 SHALL implement FSM states PASS and EXPAND; reset state PASS.
REQ-022 PASS->EXPAND SHALL occur when a token with C > 1 is accepted; remaining counter loaded with C-1, token tlast captured.
REQ-023 In EXPAND, each output advance SHALL load the next zero beat and decrement remaining; loading the final beat (remaining == 1) SHALL return to PASS.
REQ-024 An output advance SHALL be defined as tvalid_out low, or tvalid_out && tready_in.
REQ-025 tready_out SHALL equal (state == PASS) && (!tvalid_out || tready_in); it SHALL be low throughout EXPAND.
REQ-026 While tvalid_out && !tready_in, all output registers SHALL hold unchanged (no data loss, no duplication).
REQ-027 With continuous tready_in and tvalid_in, SHALL sustain one output beat per cycle, including the transition from the last zero beat to the next literal beat with no bubble.
REQ-028 pkt_count SHALL increment by 1 on each cycle with tvalid_out && tready_in && tlast_out; wraps at 2^32.
REQ-029 zero_beats SHALL increment by 1 on each zero beat loaded into the output register from a token; wraps at 2^32.
REQ-030 A token with C == 1 SHALL stay in PASS and produce one zero beat.
REQ-031 Literal beats with partial tkeep (e.g. 32'h0000FFFF) SHALL pass through unaltered.

Reset
REQ-032 On reset low, asynchronously: tvalid_out=0, tlast_out=0, data_out=0, tkeep_out=0, state=PASS, remaining=0, pkt_count=0, zero_beats=0; tready_out SHALL therefore read 1.
REQ-033 Reset asserted mid-EXPAND SHALL abort the run; no further zero beats after release.

Verification
REQ-034 Literal pass-through: beat data=all-ones, tkeep=32'hFFFFFFFF, tlast=1, tready_in=1 -> next cycle same data/tkeep, tlast_out=1; pkt_count=1.
REQ-035 Run expansion: token tkeep=0, data[15:0]=16'h0004, tlast=1 -> 4 consecutive zero beats, tkeep_out=32'hFFFFFFFF, tlast_out only on 4th, tready_out low 3 cycles; zero_beats=4, pkt_count=1.
REQ-036 Backpressure: tready_in low 5 cycles during a 3-beat run -> data_out/tvalid_out stable, exactly 3 zero beats delivered after release.
REQ-037 Count zero and mixed packet: literal (tkeep=32'h0000FFFF), token C=0, literal with tlast -> 3 output beats, middle all-zero, first keeps 32'h0000FFFF.
REQ-038 Reset mid-run: token C=100, reset low after 10 output beats -> tvalid_out=0 immediately, counters 0, PASS state, no residual beats.

Source files
------------

// File: rtl/decompressor.sv
// Run-length zero-beat decompressor for an AXI-Stream-like byte stream.
// Keep-less beats are run tokens that expand into all-zero full-keep beats.
module decompressor #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  tvalid_in,
  input  logic                  tlast_in,
  input  logic                  tready_in,
  input  logic [KEEP_WIDTH-1:0] tkeep_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tvalid_out,
  output logic                  tlast_out,
  output logic                  tready_out,
  output logic [KEEP_WIDTH-1:0] tkeep_out,
  output logic [31:0]           pkt_count,
  output logic [31:0]           zero_beats
);

  typedef enum logic {PASS, EXPAND} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  run_last_q, run_last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic [31:0]           pkt_q, pkt_d;
  logic [31:0]           zb_q, zb_d;

  logic                  advance;
  logic                  accept;
  logic                  is_tok;
  logic [CNT_WIDTH-1:0]  cnt;

  assign advance    = !valid_q || tready_in;
  assign tready_out = (state_q == PASS) && advance;
  assign accept     = tvalid_in && tready_out;
  assign is_tok     = (tkeep_in == '0);
  assign cnt        = data_in[CNT_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    run_last_d = run_last_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    valid_d    = valid_q;
    pkt_d      = pkt_q;
    zb_d       = zb_q;

    if (valid_q && tready_in && last_q)
      pkt_d = pkt_q + 32'd1;

    unique case (state_q)
      PASS: begin
        if (advance) begin
          if (accept && is_tok) begin
            valid_d = 1'b1;
            data_d  = '0;
            keep_d  = '1;
            zb_d    = zb_q + 32'd1;
            // a count of zero or one is a single zero beat
            if (cnt > CNT_WIDTH'(1)) begin
              state_d    = EXPAND;
              rem_d      = cnt - CNT_WIDTH'(1);
              run_last_d = tlast_in;
              last_d     = 1'b0;
            end else begin
              last_d = tlast_in;
            end
          end else if (accept) begin
            valid_d = 1'b1;
            data_d  = data_in;
            keep_d  = tkeep_in;
            last_d  = tlast_in;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      EXPAND: begin
        if (advance) begin
          valid_d = 1'b1;
          data_d  = '0;
          keep_d  = '1;
          zb_d    = zb_q + 32'd1;
          rem_d   = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = PASS;
            last_d  = run_last_q;
          end else begin
            last_d = 1'b0;
          end
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PASS;
      rem_q      <= '0;
      run_last_q <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      pkt_q      <= '0;
      zb_q       <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      run_last_q <= run_last_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      pkt_q      <= pkt_d;
      zb_q       <= zb_d;
    end
  end

  assign data_out   = data_q;
  assign tkeep_out  = keep_q;
  assign tlast_out  = last_q;
  assign tvalid_out = valid_q;
  assign pkt_count  = pkt_q;
  assign zero_beats = zb_q;

endmodule

// File: tb/tb_decompressor.sv
// Bench for decompressor: queue model of expected output beats,
// per-cycle compare process, and directed scenarios.
module tb_decompressor;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          tvalid_in = 1'b0;
  logic          tlast_in = 1'b0;
  logic          tready_in = 1'b1;
  logic [KW-1:0] tkeep_in = '0;
  logic [DW-1:0] data_out;
  logic          tvalid_out;
  logic          tlast_out;
  logic          tready_out;
  logic [KW-1:0] tkeep_out;
  logic [31:0]   pkt_count;
  logic [31:0]   zero_beats;

  decompressor #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .tvalid_in (tvalid_in),
    .tlast_in  (tlast_in),
    .tready_in (tready_in),
    .tkeep_in  (tkeep_in),
    .data_out  (data_out),
    .tvalid_out(tvalid_out),
    .tlast_out (tlast_out),
    .tready_out(tready_out),
    .tkeep_out (tkeep_out),
    .pkt_count (pkt_count),
    .zero_beats(zero_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    int            c;
  } beat_t;

  beat_t expq[$];
  beat_t dlog[$];

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_zero = 0;
  int cyc = 0;
  int rdy_low = 0;
  logic done5 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Expected output beats follow directly from the stream rules.
  function automatic void model_accept(input logic [DW-1:0] d,
                                       input logic [KW-1:0] k,
                                       input logic l);
    beat_t b;
    int    c;
    if (k == '0) begin
      c = int'(d[CW-1:0]);
      if (c == 0) c = 1;
      for (int i = 0; i < c; i++) begin
        b.d = '0;
        b.k = '1;
        b.l = l && (i == c - 1);
        b.c = 0;
        expq.push_back(b);
      end
      exp_zero += c;
    end else begin
      b.d = d;
      b.k = k;
      b.l = l;
      b.c = 0;
      expq.push_back(b);
    end
  endfunction

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [KW-1:0] prev_k;
  logic          prev_l;

  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tvalid_out || data_out !== prev_d ||
            tkeep_out !== prev_k || tlast_out !== prev_l) begin
          errors++;
          $display("FAIL stall_hold: v=%0b d=%0h k=%0h l=%0b",
                   tvalid_out, data_out, tkeep_out, tlast_out);
        end
      end
      checks++;
      if (pkt_count !== 32'(exp_pkt)) begin
        errors++;
        $display("FAIL pkt_count: got %0d expected %0d",
                 pkt_count, exp_pkt);
      end
      if (!tready_out) rdy_low++;
      if (tvalid_in && tready_out)
        model_accept(data_in, tkeep_in, tlast_in);
      if (tvalid_out && tready_in) begin
        checks++;
        g.d = data_out;
        g.k = tkeep_out;
        g.l = tlast_out;
        g.c = cyc;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: d=%0h k=%0h l=%0b",
                   g.d, g.k, g.l);
        end else begin
          e = expq.pop_front();
          if (g.d !== e.d || g.k !== e.k || g.l !== e.l) begin
            errors++;
            $display("FAIL beat: got d=%0h k=%0h l=%0b exp d=%0h k=%0h l=%0b",
                     g.d, g.k, g.l, e.d, e.k, e.l);
          end
        end
        dlog.push_back(g);
        if (tlast_out) exp_pkt++;
      end
      prev_stall = tvalid_out && !tready_in;
      prev_d = data_out;
      prev_k = tkeep_out;
      prev_l = tlast_out;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l);
    int t = 0;
    data_in   = d;
    tkeep_in  = k;
    tlast_in  = l;
    tvalid_in = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!tready_out && t < 500);
    checks++;
    if (!tready_out) begin
      errors++;
      $display("FAIL send_timeout: tready_out=%0b expected 1", tready_out);
    end
    @(posedge clk);
    #1;
    tvalid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || tvalid_out) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", DW'(expq.size()), '0);
    chk("drain_valid", DW'(tvalid_out), '0);
    chk("zero_model", DW'(zero_beats), DW'(exp_zero));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n0;
    int            t;
    logic [DW-1:0] ones;
    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    ones = '1;
    pa   = {8{32'hA5A5_0001}};
    pb   = {8{32'h1234_5678}};

    #1;
    chk("rst_valid", DW'(tvalid_out), '0);
    chk("rst_last", DW'(tlast_out), '0);
    chk("rst_data", data_out, '0);
    chk("rst_keep", DW'(tkeep_out), '0);
    chk("rst_ready", DW'(tready_out), DW'(1));
    chk("rst_pkt", DW'(pkt_count), '0);
    chk("rst_zero", DW'(zero_beats), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // literal pass-through
    n0 = dlog.size();
    send(ones, 32'hFFFF_FFFF, 1'b1);
    drain();
    chk("lit_pkt", DW'(pkt_count), DW'(1));
    chk("lit_n", DW'(dlog.size() - n0), DW'(1));
    chk("lit_d", dlog[n0].d, ones);
    chk("lit_l", DW'(dlog[n0].l), DW'(1));

    // 4-beat run followed directly by a literal
    rdy_low = 0;
    n0 = dlog.size();
    send(DW'(16'h0004), '0, 1'b1);
    send(pb, 32'hFFFF_FFFF, 1'b0);
    drain();
    chk("run_rdy_low", DW'(rdy_low), DW'(3));
    chk("run_zero", DW'(zero_beats), DW'(4));
    chk("run_pkt", DW'(pkt_count), DW'(2));
    chk("run_n", DW'(dlog.size() - n0), DW'(5));
    for (int i = 0; i < 4; i++) begin
      chk("run_d", dlog[n0 + i].d, '0);
      chk("run_k", DW'(dlog[n0 + i].k), DW'(32'hFFFF_FFFF));
      chk("run_l", DW'(dlog[n0 + i].l), DW'(i == 3));
    end
    chk("run_lit", dlog[n0 + 4].d, pb);
    chk("no_bubble", DW'(dlog[n0 + 4].c - dlog[n0].c), DW'(4));

    // backpressure during a 3-beat run
    n0 = dlog.size();
    send(DW'(16'h0003), '0, 1'b0);
    tready_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid", DW'(tvalid_out), DW'(1));
    chk("bp_data", data_out, '0);
    tready_in = 1'b1;
    drain();
    chk("bp_n", DW'(dlog.size() - n0), DW'(3));
    chk("bp_zero", DW'(zero_beats), DW'(7));

    // count-zero token inside a mixed packet
    rdy_low = 0;
    n0 = dlog.size();
    send(pa, 32'h0000_FFFF, 1'b0);
    send('0, '0, 1'b0);
    send(pb, 32'hFFFF_FFFF, 1'b1);
    drain();
    chk("mix_n", DW'(dlog.size() - n0), DW'(3));
    chk("mix_k0", DW'(dlog[n0].k), DW'(32'h0000_FFFF));
    chk("mix_d0", dlog[n0].d, pa);
    chk("mix_d1", dlog[n0 + 1].d, '0);
    chk("mix_k1", DW'(dlog[n0 + 1].k), DW'(32'hFFFF_FFFF));
    chk("mix_l2", DW'(dlog[n0 + 2].l), DW'(1));
    chk("mix_rdy", DW'(rdy_low), '0);
    chk("mix_zero", DW'(zero_beats), DW'(8));
    chk("mix_pkt", DW'(pkt_count), DW'(3));

    // mixed traffic under a repeating ready pattern
    done5 = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 0)
            send({8{32'(i + 7)}}, 32'hFFFF_FFFF >> (i * 4), i == 6);
          else
            send(DW'(i), '0, (i % 4) == 3);
        end
        done5 = 1'b1;
      end
      begin
        int j = 0;
        while (!done5) begin
          @(posedge clk);
          #1;
          tready_in = (j % 3 != 1);
          j++;
        end
        tready_in = 1'b1;
      end
    join
    drain();

    // reset in the middle of a long run
    n0 = dlog.size();
    send(DW'(16'd100), '0, 1'b1);
    t = 0;
    while (dlog.size() - n0 < 10 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mid_n", DW'(dlog.size() - n0), DW'(10));
    reset = 1'b0;
    expq.delete();
    exp_pkt = 0;
    exp_zero = 0;
    #1;
    chk("mid_valid", DW'(tvalid_out), '0);
    chk("mid_ready", DW'(tready_out), DW'(1));
    chk("mid_pkt", DW'(pkt_count), '0);
    chk("mid_zero", DW'(zero_beats), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n0 = dlog.size();
    repeat (20) @(posedge clk);
    #1;
    chk("post_n", DW'(dlog.size() - n0), '0);
    chk("post_valid", DW'(tvalid_out), '0);
    chk("post_zero", DW'(zero_beats), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
